ram_bist_ctrl: RTL
==================

# ram_bist_ctrl

Synthesizable built-in self-test initiator for `single_port_ram`. It drives the RAM's shared `cs`/`we`/`oe`/`addr`/`data` bus with a three-phase march sequence: write, read-compare-invert, then descending read-compare. It reads back every location and reports pass/fail, the first failing address, and an error count. It sits between the RAM and the chip's test/status logic, and it replaces testbench-only fill-and-read stimulus in silicon.

## Interface
Parameters:
- `ADDRWIDTH`, 4, RAM address width
- `DATAWIDTH`, 8, RAM data width
- `SIZE`, 16, number of locations tested (addresses 0..SIZE-1, SIZE ≤ 2**ADDRWIDTH)
- `SEED`, 8'hA5, pattern seed; truncated/zero-extended to DATAWIDTH

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle request to begin a test; ignored while `busy`
- `busy`  out  1  high from the cycle after accepted `start` until `done`
- `done`  out  1  one-cycle pulse when the test completes
- `pass`  out  1  valid from `done`; held until next accepted `start`
- `fail_addr`  out  ADDRWIDTH  address of the first miscompare; 0 if none
- `fail_phase`  out  2  phase of the first miscompare: 2 or 3; 0 if none
- `err_count`  out  ADDRWIDTH+2  miscompare count, saturating at all-ones
- `addr`  out  ADDRWIDTH  RAM address
- `data`  inout  DATAWIDTH  RAM data bus; driven only while `cs & we`, else `'hz`
- `cs`, `we`, `oe`  out  1 each  RAM chip select, write enable, output enable

## Operation
- Pattern: P(a) = a[DATAWIDTH-1:0] XOR SEED, where `a` is zero-extended/truncated to DATAWIDTH.
- States:
  - IDLE → PH1_WR on `start`.
  - PH1_WR: one write per cycle, a = 0..SIZE-1, `cs=1 we=1 oe=0`, data = P(a).
  - TURN1: `cs=0 we=0 oe=0`, bus undriven.
  - PH2, ascending, 3 cycles per address:
    - RD: `cs=1 we=0 oe=1`.
    - CMP: `cs=0 oe=1`; sample `data` and compare with P(a).
    - WR: `cs=1 we=1 oe=0`; data = ~P(a).
  - TURN2: same as TURN1.
  - PH3, descending a = SIZE-1..0, 2 cycles per address:
    - RD.
    - CMP against ~P(a).
  - DONE: one cycle, `done=1` → IDLE.
- Read latency: the RAM presents read data during the cycle after RD. The controller samples it at the posedge that ends CMP.
- Miscompare handling:
  - `err_count` increments (saturating).
  - On the first miscompare only, `fail_addr`/`fail_phase` latch.
- `pass` = (`err_count` == 0) at DONE.
- Accepted `start` clears `pass`, `err_count`, `fail_addr`, `fail_phase`.
- `oe` and the controller's data driver are never active in the same cycle. The driver is enabled only in PH1_WR and PH2 WR.

## Timing
- Reset values: `busy=0 done=0 pass=0 fail_addr=0 fail_phase=0 err_count=0 cs=0 we=0 oe=0 addr=0`, data undriven. All outputs are registered.
- Reset mid-test: the bus is released immediately (async), the FSM goes to IDLE, and no `done` pulse is issued.
- `start` sampled high in IDLE → first PH1 write appears on the bus the next cycle, with `busy=1` in that cycle.
- Test duration: `busy` is high for 6·SIZE+3 cycles, including DONE. For SIZE=16 that is 99 cycles.
- `start` while `busy` or in the DONE cycle: ignored.
- Address counters:
  - Counter width is ADDRWIDTH+1, so SIZE = 2**ADDRWIDTH terminates cleanly.
  - The descending counter ends after a = 0 with no wrap write.
- `err_count` holds at 2**(ADDRWIDTH+2)-1 once saturated.

## Structure
- `ram_bist_pkg` holds:
  - the state enum (IDLE, PH1_WR, TURN1, PH2_RD, PH2_CMP, PH2_WR, TURN2, PH3_RD, PH3_CMP, DONE)
  - phase codes (PH2=2'd2, PH3=2'd3)
  - the pattern function P
- One sub-module, `ram_bist_cmp`: registered comparator plus saturating error counter and first-fail latch.
- The FSM, address counter and tristate driver stay in the top.

## Test plan
- Good RAM, SIZE=16, SEED=8'hA5, `start` pulse:
  - `done` exactly 99 cycles later, `pass=1`, `err_count=0`.
  - Location 3 ends holding 8'h59 (~(3^A5)).
- Stuck-at bit 0 at address 5 (RAM model forces read bit 0 = 1; P(5)=8'hA0):
  - `fail_addr=5`, `fail_phase=2`, `err_count=1`, `pass=0`.
- Two faults (addr 9 in PH2, addr 2 in PH3):
  - `fail_addr=9`, `fail_phase=2`, `err_count=2`.
- Bus checker over the whole run:
  - Never `oe=1` with controller driving.
  - A `cs=0` cycle separates every write→read transition.
  - `data` is Z whenever `we=0`.
- `rst_n` low at cycle 40 of the test:
  - All outputs at reset values within the same cycle, bus Z, no `done`.
  - A new `start` afterwards completes with `pass=1`.
- `start` re-asserted at cycles 10 and 98 of a run:
  - Both ignored, single `done`.
  - A second test after `done` clears the previous error results.

Source files
------------

// File: rtl/ram_bist_pkg.sv
// Shared types and helpers for the RAM march-test controller.
// Holds the FSM state encoding, phase codes and the test pattern generator.
package ram_bist_pkg;

    typedef enum logic [3:0] {
        IDLE,
        PH1_WR,
        TURN1,
        PH2_RD,
        PH2_CMP,
        PH2_WR,
        TURN2,
        PH3_RD,
        PH3_CMP,
        DONE
    } bist_state_t;

    localparam logic [1:0] PH_NONE = 2'd0;
    localparam logic [1:0] PH2     = 2'd2;
    localparam logic [1:0] PH3     = 2'd3;

    // Callers pass zero-extended address/seed and truncate the result to
    // their data width, which gives P(a) = a[DW-1:0] ^ SEED.
    function automatic logic [31:0] bist_pattern(input logic [31:0] a,
                                                 input logic [31:0] seed);
        return a ^ seed;
    endfunction

endpackage

// File: rtl/ram_bist_if.sv
// Control strobes between the BIST controller and the single-port RAM.
// The bidirectional data bus is a plain inout on the controller.
interface ram_bist_if #(
    parameter int ADDRWIDTH = 4
);
    logic [ADDRWIDTH-1:0] addr;
    logic                 cs;
    logic                 we;
    logic                 oe;

    modport master (output addr, cs, we, oe);
    modport slave  (input  addr, cs, we, oe);
endinterface

// File: rtl/ram_bist_cmp.sv
// Read-data comparator: saturating miscompare counter and first-fail latch.
// Samples the bus at the clock edge that ends each compare cycle.
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int ADDRWIDTH = 4,
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 cmp_en,
    input  logic [DATAWIDTH-1:0] rd_data,
    input  logic [DATAWIDTH-1:0] exp_data,
    input  logic [ADDRWIDTH-1:0] cmp_addr,
    input  logic [1:0]           cmp_phase,
    output logic                 clean,
    output logic [ADDRWIDTH-1:0] fail_addr,
    output logic [1:0]           fail_phase,
    output logic [ADDRWIDTH+1:0] err_count
);

    logic mis;

    assign mis = cmp_en && (rd_data != exp_data);

    // No errors so far and none arriving this cycle; lets the top form
    // the pass flag on the same edge as the final comparison.
    assign clean = (err_count == '0) && !mis;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            fail_addr  <= '0;
            fail_phase <= PH_NONE;
        end else if (clr) begin
            err_count  <= '0;
            fail_addr  <= '0;
            fail_phase <= PH_NONE;
        end else if (mis) begin
            if (err_count != '1)
                err_count <= err_count + 1'b1;
            if (err_count == '0) begin
                fail_addr  <= cmp_addr;
                fail_phase <= cmp_phase;
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// March-test BIST initiator for a single-port RAM: ascending write,
// ascending read/compare/invert-write, descending read/compare.
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                   ADDRWIDTH = 4,
    parameter int                   DATAWIDTH = 8,
    parameter int                   SIZE      = 16,
    parameter logic [DATAWIDTH-1:0] SEED      = DATAWIDTH'(8'hA5)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ADDRWIDTH-1:0] fail_addr,
    output logic [1:0]           fail_phase,
    output logic [ADDRWIDTH+1:0] err_count,
    ram_bist_if.master           ram,
    inout  wire  [DATAWIDTH-1:0] data
);

    localparam int CW = ADDRWIDTH + 1;
    typedef logic [CW-1:0] cnt_t;
    localparam cnt_t SIZE_C = cnt_t'(SIZE);
    localparam cnt_t LAST   = cnt_t'(SIZE - 1);

    function automatic logic [DATAWIDTH-1:0] pat(input cnt_t a);
        return DATAWIDTH'(bist_pattern(32'(a), 32'(SEED)));
    endfunction

    bist_state_t          state, state_nxt;
    cnt_t                 cnt, cnt_nxt, cnt_inc;
    logic                 start_acc;

    logic                 cs_q, we_q, oe_q;
    logic [ADDRWIDTH-1:0] addr_q;
    logic [DATAWIDTH-1:0] wdata_q;

    logic                 cs_n, we_n, oe_n, busy_n, done_n;
    logic [ADDRWIDTH-1:0] addr_n;
    logic [DATAWIDTH-1:0] wdata_n;

    logic                 cmp_en, clean;
    logic [DATAWIDTH-1:0] exp_data;
    logic [1:0]           cmp_phase;

    assign cnt_inc   = cnt + cnt_t'(1);
    assign start_acc = (state == IDLE) && start;

    // State and registered outputs; outputs are decoded from the next
    // state so every bus strobe comes straight from a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            oe_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            busy    <= busy_n;
            done    <= done_n;
            cs_q    <= cs_n;
            we_q    <= we_n;
            oe_q    <= oe_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            if (start_acc)
                pass <= 1'b0;
            else if (state_nxt == DONE)
                pass <= clean;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = PH1_WR;
                    cnt_nxt   = '0;
                end
            end
            PH1_WR: begin
                if (cnt_inc == SIZE_C) begin
                    state_nxt = TURN1;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            TURN1:   state_nxt = PH2_RD;
            PH2_RD:  state_nxt = PH2_CMP;
            PH2_CMP: state_nxt = PH2_WR;
            PH2_WR: begin
                if (cnt_inc == SIZE_C) begin
                    state_nxt = TURN2;
                    cnt_nxt   = LAST;
                end else begin
                    state_nxt = PH2_RD;
                    cnt_nxt   = cnt_inc;
                end
            end
            TURN2:   state_nxt = PH3_RD;
            PH3_RD:  state_nxt = PH3_CMP;
            PH3_CMP: begin
                // Stop after address 0 rather than decrementing past it.
                if (cnt == '0) begin
                    state_nxt = DONE;
                    cnt_nxt   = '0;
                end else begin
                    state_nxt = PH3_RD;
                    cnt_nxt   = cnt - cnt_t'(1);
                end
            end
            DONE:    state_nxt = IDLE;
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        cs_n    = 1'b0;
        we_n    = 1'b0;
        oe_n    = 1'b0;
        wdata_n = '0;
        addr_n  = cnt_nxt[ADDRWIDTH-1:0];
        busy_n  = (state_nxt != IDLE);
        done_n  = (state_nxt == DONE);
        unique case (state_nxt)
            PH1_WR: begin
                cs_n    = 1'b1;
                we_n    = 1'b1;
                wdata_n = pat(cnt_nxt);
            end
            PH2_RD, PH3_RD: begin
                cs_n = 1'b1;
                oe_n = 1'b1;
            end
            PH2_CMP, PH3_CMP: oe_n = 1'b1;
            PH2_WR: begin
                cs_n    = 1'b1;
                we_n    = 1'b1;
                wdata_n = ~pat(cnt_nxt);
            end
            default: begin
                cs_n = 1'b0;
            end
        endcase
    end

    assign cmp_en    = (state == PH2_CMP) || (state == PH3_CMP);
    assign exp_data  = (state == PH3_CMP) ? ~pat(cnt) : pat(cnt);
    assign cmp_phase = (state == PH3_CMP) ? PH3 : PH2;

    ram_bist_cmp #(
        .ADDRWIDTH (ADDRWIDTH),
        .DATAWIDTH (DATAWIDTH)
    ) u_cmp (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (start_acc),
        .cmp_en     (cmp_en),
        .rd_data    (data),
        .exp_data   (exp_data),
        .cmp_addr   (cnt[ADDRWIDTH-1:0]),
        .cmp_phase  (cmp_phase),
        .clean      (clean),
        .fail_addr  (fail_addr),
        .fail_phase (fail_phase),
        .err_count  (err_count)
    );

    assign ram.addr = addr_q;
    assign ram.cs   = cs_q;
    assign ram.we   = we_q;
    assign ram.oe   = oe_q;

    // Write data is only ever driven alongside a write strobe, so it can
    // never overlap the RAM driving the bus under oe.
    assign data = (cs_q && we_q) ? wdata_q : {DATAWIDTH{1'bz}};

endmodule
